// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: en/mode/sr_i/par_i commands in,
// sr_o/ser_o/cnt_o/done status out. master drives, slave is the register.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             en;
   logic [2:0]       mode;
   logic             sr_i;
   logic [WIDTH-1:0] par_i;
   logic [WIDTH-1:0] sr_o;
   logic             ser_o;
   logic [CNT_W-1:0] cnt_o;
   logic             done;

   modport master (
      output en, mode, sr_i, par_i,
      input  sr_o, ser_o, cnt_o, done
   );

   modport slave (
      input  en, mode, sr_i, par_i,
      output sr_o, ser_o, cnt_o, done
   );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/asr/load/clear with serial out,
// shift counter and word-complete pulse. Ports: clk, reset (async low), bus.
module univ_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic             clk,
   input logic             reset,
   univ_shift_reg_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_ROL  = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_LOAD = 3'b101;
   localparam logic [2:0] M_CLR  = 3'b110;
   localparam logic [2:0] M_ASR  = 3'b111;

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_nxt;
   logic             ser_q;
   logic             ser_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic             shift;
   logic             clr_cnt;

   always_comb begin
      sr_nxt  = sr_q;
      ser_nxt = ser_q;
      shift   = 1'b0;
      clr_cnt = 1'b0;
      unique case (bus.mode)
         M_HOLD: begin
         end
         M_SHL: begin
            sr_nxt  = {sr_q[WIDTH-2:0], bus.sr_i};
            ser_nxt = sr_q[WIDTH-1];
            shift   = 1'b1;
         end
         M_SHR: begin
            sr_nxt  = {bus.sr_i, sr_q[WIDTH-1:1]};
            ser_nxt = sr_q[0];
            shift   = 1'b1;
         end
         M_ROL: begin
            sr_nxt  = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
            ser_nxt = sr_q[WIDTH-1];
            shift   = 1'b1;
         end
         M_ROR: begin
            sr_nxt  = {sr_q[0], sr_q[WIDTH-1:1]};
            ser_nxt = sr_q[0];
            shift   = 1'b1;
         end
         M_LOAD: begin
            sr_nxt  = bus.par_i;
            ser_nxt = 1'b0;
            clr_cnt = 1'b1;
         end
         M_CLR: begin
            sr_nxt  = '0;
            ser_nxt = 1'b0;
            clr_cnt = 1'b1;
         end
         M_ASR: begin
            sr_nxt  = {sr_q[WIDTH-1], sr_q[WIDTH-1:1]};
            ser_nxt = sr_q[0];
            shift   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q   <= RST_VAL;
         ser_q  <= 1'b0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         // done is a pulse; it only survives the cycle after a wrap
         done_q <= 1'b0;
         if (bus.en) begin
            sr_q  <= sr_nxt;
            ser_q <= ser_nxt;
            if (clr_cnt) begin
               cnt_q <= '0;
            end else if (shift) begin
               if (cnt_q == CNT_MAX) begin
                  cnt_q  <= '0;
                  done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign bus.sr_o  = sr_q;
   assign bus.ser_o = ser_q;
   assign bus.cnt_o = cnt_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg at WIDTH 8, 2 and 17.
// Table-driven vectors on the 8-bit instance plus hand-written sequences.
module tb_univ_shift_reg;
   localparam logic [2:0] HOLD = 3'b000;
   localparam logic [2:0] SHL  = 3'b001;
   localparam logic [2:0] SHR  = 3'b010;
   localparam logic [2:0] ROL  = 3'b011;
   localparam logic [2:0] ROR  = 3'b100;
   localparam logic [2:0] LOAD = 3'b101;
   localparam logic [2:0] CLR  = 3'b110;
   localparam logic [2:0] ASR  = 3'b111;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   univ_shift_reg_if #(.WIDTH(8))  b8 ();
   univ_shift_reg_if #(.WIDTH(2))  b2 ();
   univ_shift_reg_if #(.WIDTH(17)) b17 ();

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) u8 (
      .clk(clk), .reset(reset), .bus(b8)
   );
   univ_shift_reg #(.WIDTH(2)) u2 (
      .clk(clk), .reset(reset), .bus(b2)
   );
   univ_shift_reg #(.WIDTH(17)) u17 (
      .clk(clk), .reset(reset), .bus(b17)
   );

   typedef struct {
      string      name;
      logic       en;
      logic [2:0] mode;
      logic       sr_i;
      logic [7:0] par_i;
      logic [7:0] sr;
      logic       ser;
      logic [3:0] cnt;
      logic       done;
   } vec_t;

   vec_t vq[$];

   task automatic add(input string name, input logic en,
                      input logic [2:0] mode, input logic sr_i,
                      input logic [7:0] par_i, input logic [7:0] sr,
                      input logic ser, input logic [3:0] cnt,
                      input logic done);
      vec_t v;
      v.name = name; v.en = en; v.mode = mode; v.sr_i = sr_i;
      v.par_i = par_i; v.sr = sr; v.ser = ser; v.cnt = cnt;
      v.done = done;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] st8();
      return 32'({b8.sr_o, b8.ser_o, b8.cnt_o, b8.done});
   endfunction

   function automatic logic [31:0] st2();
      return 32'({b2.sr_o, b2.ser_o, b2.cnt_o, b2.done});
   endfunction

   function automatic logic [31:0] st17();
      return 32'({b17.sr_o, b17.ser_o, b17.cnt_o, b17.done});
   endfunction

   task automatic drv8(input logic en, input logic [2:0] mode,
                       input logic sr_i, input logic [7:0] par_i);
      b8.en = en; b8.mode = mode; b8.sr_i = sr_i; b8.par_i = par_i;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  b4;
      logic [16:0] exp17;
      logic [1:0]  exp2;
      int          d2;
      int          d17;
      int          max2;
      int          max17;

      // serial fill
      add("fill_load", 1, LOAD, 0, 8'h00, 8'h00, 0, 0, 0);
      for (int i = 1; i <= 8; i++)
         add("fill_shl", 1, SHL, 1, 8'h55, 8'((1 << i) - 1), 0,
             4'(i % 8), i == 8);
      // rotate / arithmetic
      add("rot_load", 1, LOAD, 0, 8'h81, 8'h81, 0, 0, 0);
      add("ror",      1, ROR,  0, 8'h00, 8'hC0, 1, 1, 0);
      add("asr",      1, ASR,  1, 8'h00, 8'hE0, 0, 2, 0);
      add("rol",      1, ROL,  0, 8'h00, 8'hC1, 1, 3, 0);
      // SHR serial out, LSB first
      b4 = 8'hB4;
      add("shr_load", 1, LOAD, 0, 8'hB4, 8'hB4, 0, 0, 0);
      for (int k = 1; k <= 8; k++)
         add("shr", 1, SHR, 0, 8'h00, b4 >> k, b4[k-1],
             4'(k % 8), k == 8);
      // enable drop mid-word
      add("en_load", 1, LOAD, 0, 8'h00, 8'h00, 0, 0, 0);
      add("en_shl1", 1, SHL, 1, 8'h00, 8'h01, 0, 1, 0);
      add("en_shl2", 1, SHL, 1, 8'h00, 8'h03, 0, 2, 0);
      add("en_shl3", 1, SHL, 1, 8'h00, 8'h07, 0, 3, 0);
      add("en_off1", 0, LOAD, 1, 8'hFF, 8'h07, 0, 3, 0);
      add("en_off2", 0, CLR,  1, 8'hFF, 8'h07, 0, 3, 0);
      add("en_off3", 0, SHL,  1, 8'hFF, 8'h07, 0, 3, 0);
      add("en_off4", 0, ROR,  0, 8'hFF, 8'h07, 0, 3, 0);
      add("en_off5", 0, ASR,  1, 8'hFF, 8'h07, 0, 3, 0);
      add("en_shl4", 1, SHL, 1, 8'h00, 8'h0F, 0, 4, 0);
      add("en_shl5", 1, SHL, 1, 8'h00, 8'h1F, 0, 5, 0);
      add("en_shl6", 1, SHL, 1, 8'h00, 8'h3F, 0, 6, 0);
      add("en_shl7", 1, SHL, 1, 8'h00, 8'h7F, 0, 7, 0);
      add("en_shl8", 1, SHL, 1, 8'h00, 8'hFF, 0, 0, 1);
      // load mid-word
      add("mw_shl1", 1, SHL, 0, 8'h00, 8'hFE, 1, 1, 0);
      add("mw_shl2", 1, SHL, 0, 8'h00, 8'hFC, 1, 2, 0);
      add("mw_shl3", 1, SHL, 0, 8'h00, 8'hF8, 1, 3, 0);
      add("mw_shl4", 1, SHL, 0, 8'h00, 8'hF0, 1, 4, 0);
      add("mw_load", 1, LOAD, 0, 8'h3C, 8'h3C, 0, 0, 0);
      add("hold",    1, HOLD, 1, 8'hFF, 8'h3C, 0, 0, 0);
      // clear mid-word
      add("cl_ror1", 1, ROR, 0, 8'h00, 8'h1E, 0, 1, 0);
      add("cl_ror2", 1, ROR, 0, 8'h00, 8'h0F, 0, 2, 0);
      add("clr",     1, CLR, 1, 8'hFF, 8'h00, 0, 0, 0);

      drv8(0, HOLD, 0, 8'h00);
      b2.en = 0; b2.mode = HOLD; b2.sr_i = 0; b2.par_i = '0;
      b17.en = 0; b17.mode = HOLD; b17.sr_i = 0; b17.par_i = '0;

      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("rst_w8", st8(), 32'({8'hA5, 1'b0, 4'd0, 1'b0}));
      chk("rst_w2", st2(), 32'({2'b00, 1'b0, 2'd0, 1'b0}));
      chk("rst_w17", st17(), 32'({17'h0, 1'b0, 5'd0, 1'b0}));
      #10 reset = 1'b1;
      tick();

      foreach (vq[i]) begin
         drv8(vq[i].en, vq[i].mode, vq[i].sr_i, vq[i].par_i);
         tick();
         chk(vq[i].name, st8(),
             32'({vq[i].sr, vq[i].ser, vq[i].cnt, vq[i].done}));
      end

      // back-to-back words at WIDTH 2 and 17
      b2.en = 1; b2.mode = LOAD; b2.par_i = '0;
      b17.en = 1; b17.mode = LOAD; b17.par_i = '0;
      tick();
      chk("p_load_w2", st2(), 32'd0);
      chk("p_load_w17", st17(), 32'd0);
      b2.mode = SHL; b2.sr_i = 1;
      b17.mode = SHL; b17.sr_i = 1;
      d2 = 0; d17 = 0; max2 = 0; max17 = 0;
      for (int i = 1; i <= 51; i++) begin
         tick();
         exp2  = (i >= 2)  ? '1 : 2'((1 << i) - 1);
         exp17 = (i >= 17) ? '1 : 17'((1 << i) - 1);
         chk("p_w2", st2(), 32'({exp2, i > 2, 2'(i % 2),
                                 i % 2 == 0}));
         chk("p_w17", st17(), 32'({exp17, i > 17, 5'(i % 17),
                                   i % 17 == 0}));
         if (b2.done) d2++;
         if (b17.done) d17++;
         if (int'(b2.cnt_o) > max2) max2 = int'(b2.cnt_o);
         if (int'(b17.cnt_o) > max17) max17 = int'(b17.cnt_o);
      end
      chk("p_done_w2", 32'(d2), 32'd25);
      chk("p_done_w17", 32'(d17), 32'd3);
      chk("p_max_w2", 32'(max2), 32'd1);
      chk("p_max_w17", 32'(max17), 32'd16);
      b2.en = 0; b17.en = 0;

      // async reset mid-word, then first edge from reset state
      drv8(1, LOAD, 0, 8'h0F);
      tick();
      drv8(1, SHL, 1, 8'h00);
      tick();
      tick();
      chk("rw_pre", st8(), 32'({8'h3F, 1'b0, 4'd2, 1'b0}));
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("rw_rst_w8", st8(), 32'({8'hA5, 1'b0, 4'd0, 1'b0}));
      chk("rw_rst_w2", st2(), 32'd0);
      chk("rw_rst_w17", st17(), 32'd0);
      #2 reset = 1'b1;
      tick();
      chk("rw_first", st8(), 32'({8'h4B, 1'b1, 4'd1, 1'b0}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's fixed 4-bit serial-in/parallel-out shift register.
- Adds:
  - configurable width
  - a mode-selected operation set: shift, rotate, arithmetic shift, parallel load, clear
  - registered serial output
  - a shift counter with a word-complete pulse
- Used as a serialiser/deserialiser front end for bit-serial links and for test-pattern generation.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RST_VAL, 0, value loaded into sr_o on reset; WIDTH bits.
- CNT_W (localparam), $clog2(WIDTH+1), width of cnt_o; derived, not overridable.

Ports:
- clk    input   1        rising-edge clock
- reset  input   1        asynchronous, active-low reset
- en     input   1        operation enable; low = hold all state
- mode   input   3        operation select (see Behaviour)
- sr_i   input   1        serial input bit
- par_i  input   WIDTH    parallel load data
- sr_o   output  WIDTH    register contents (registered)
- ser_o  output  1        bit shifted/rotated out by the last shift op (registered)
- cnt_o  output  CNT_W    shift ops since last load/clear/wrap (registered)
- done   output  1        one-cycle pulse: WIDTH-th shift op since last load/clear

Behaviour:
- Reset (reset == 0, asynchronous, immediate, overrides all):
  - sr_o = RST_VAL
  - ser_o = 0
  - cnt_o = 0
  - done = 0
- All outputs are registered.
- Every operation takes effect on the rising edge where en == 1, and is visible the following cycle (1-cycle latency).
- en == 0: sr_o, ser_o and cnt_o hold; done = 0.
- mode encoding (applied when en == 1):
  - 000 HOLD: sr_o, ser_o and cnt_o hold; done = 0.
  - 001 SHL: sr_o <= {sr_o[WIDTH-2:0], sr_i}; ser_o <= sr_o[WIDTH-1]. Matches the predecessor's serial fill direction (sr_i enters the LSB).
  - 010 SHR: sr_o <= {sr_i, sr_o[WIDTH-1:1]}; ser_o <= sr_o[0].
  - 011 ROL: sr_o <= {sr_o[WIDTH-2:0], sr_o[WIDTH-1]}; ser_o <= sr_o[WIDTH-1]; sr_i ignored.
  - 100 ROR: sr_o <= {sr_o[0], sr_o[WIDTH-1:1]}; ser_o <= sr_o[0]; sr_i ignored.
  - 101 LOAD: sr_o <= par_i; ser_o <= 0; cnt_o <= 0; done = 0.
  - 110 CLR: sr_o <= 0; ser_o <= 0; cnt_o <= 0; done = 0.
  - 111 ASR: sr_o <= {sr_o[WIDTH-1], sr_o[WIDTH-1:1]}, MSB replicated; ser_o <= sr_o[0]; sr_i ignored.
- Shift ops are SHL, SHR, ROL, ROR and ASR.
- Counter rules:
  - Each enabled shift op: if cnt_o == WIDTH-1, then cnt_o <= 0 and done <= 1 for exactly one cycle; otherwise cnt_o <= cnt_o + 1 and done <= 0.
  - done is registered; it is high in the cycle after the WIDTH-th shift edge.
  - Back-to-back words: shifting continuously gives done once every WIDTH shift cycles with no gap.
  - LOAD/CLR mid-word: discards partial count (cnt_o = 0); no done pulse.
  - en dropped mid-word: count frozen and resumed on re-enable; gaps do not reset the count.
  - Mixing shift op types within a word is legal; all shift ops count equally.
- Reset mid-word: all state cleared immediately; the first edge after release behaves as from reset.
- mode changes are legal on any cycle; no illegal codes.
- No X on outputs after reset.
  - X on mode/sr_i/par_i while en == 0 must not disturb state.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5, reset low mid-run, asynchronous to clk -> sr_o=8'hA5, ser_o=0, cnt_o=0, done=0 immediately, without waiting for a clock edge.
- Serial fill: LOAD 8'h00, then SHL with sr_i=1 for 8 cycles:
  - sr_o steps 01, 03, 07, ..., FF
  - cnt_o steps 1..7, then 0
  - done high exactly one cycle after the 8th edge
  - ser_o=0 throughout
- Rotate/arith: LOAD 8'h81, ROR x1 -> sr_o=8'hC0, ser_o=1. Then ASR x1 -> sr_o=8'hE0, ser_o=0. Then ROL x1 -> sr_o=8'hC1, ser_o=1.
- SHR serial out: LOAD 8'hB4, SHR with sr_i=0 for 8 cycles:
  - ser_o sequence LSB-first 0,0,1,0,1,1,0,1
  - final sr_o=8'h00
  - done pulses once
- Enable/interrupt: LOAD 8'h00, SHL x3, drop en for 5 cycles (mode toggling) -> sr_o and cnt_o=3 frozen. Then SHL x5 -> done on 5th. Then LOAD mid-word after SHL x4 -> cnt_o=0, no done.
- Parametrisation: rerun the serial-fill and back-to-back scenarios at WIDTH=2 and WIDTH=17 (continuous SHL for 3*WIDTH cycles) -> done every WIDTH cycles, cnt_o never exceeds WIDTH-1.
